// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_state_t : FSM states of the fetch controller
//   if_id_t       : one IF/ID boundary entry {valid, pc, raw_instr, misalign}
//   PC_RESET_DEFAULT : default reset PC
package fetch_stage_pkg;

    // Width of the pc field inside if_id_t; the fetch stage XLEN must match it.
    localparam int unsigned XLEN_P = 64;
    localparam logic [XLEN_P-1:0] PC_RESET_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN_P-1:0] pc;
        logic [31:0]       raw_instr;
        logic              misalign;
    } if_id_t;

    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
//   redirect_valid_i / redirect_pc_i : flush target, highest priority
//   advance_i                        : current word was fetched, step to pc+4
//   pc_i                             : current PC
//   pc_o                             : next PC (wraps modulo 2^XLEN)
module fetch_pc_sel #(
    parameter int unsigned XLEN = 64
) (
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_o
);

    always_comb begin
        pc_o = pc_i;
        if (redirect_valid_i) begin
            pc_o = redirect_pc_i;
        end else if (advance_i) begin
            pc_o = pc_i + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the decoder.
// Owns the PC, issues word fetches on the instruction bus and presents
// {pc, raw_instr, misalign} to IF/ID through a valid/ready handshake.
//   clk, reset                     : clock, synchronous active-high reset
//   ireq_valid / ireq_addr         : bus request, held stable until iresp_data_ok
//   iresp_data_ok / iresp_data     : one response pulse per accepted request
//   redirect_valid / redirect_pc   : flush and restart at a new PC
//   out_valid / out_ready          : IF/ID handshake
//   out_pc / out_instr / out_misalign : IF/ID entry contents
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       XLEN     = XLEN_P,
    parameter logic [XLEN-1:0]   PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_misalign
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    if_id_t          out_q, out_d;
    if_id_t          pend_q, pend_d;
    if_id_t          resp_entry;
    if_id_t          fault_entry;

    logic pc_ok;
    logic slot_free;
    logic req_active;
    logic resp_take;
    logic advance;

    assign pc_ok     = pc_aligned(pc_q[1:0]);
    assign slot_free = !out_q.valid || out_ready;

    // A request is on the bus whenever we are fetching an aligned PC or
    // waiting out a response that a redirect has orphaned.
    assign req_active = !reset && ((state_q == FETCH && pc_ok) || state_q == DISCARD);
    assign resp_take  = req_active && iresp_data_ok;

    assign ireq_valid = req_active;
    assign ireq_addr  = req_addr_q;

    assign resp_entry  = '{valid: 1'b1, pc: req_addr_q, raw_instr: iresp_data, misalign: 1'b0};
    assign fault_entry = '{valid: 1'b1, pc: pc_q, raw_instr: 32'h0, misalign: 1'b1};

    fetch_pc_sel #(
        .XLEN(XLEN)
    ) u_pc_sel (
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .advance_i       (advance),
        .pc_i            (pc_q),
        .pc_o            (pc_d)
    );

    // The request address may only move once the outstanding request has
    // been answered; otherwise it shadows the next PC so that a new request
    // always starts at the current PC.
    assign req_addr_d = (req_active && !iresp_data_ok) ? req_addr_q : pc_d;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pend_d  = pend_q;
        advance = 1'b0;

        if (out_q.valid && out_ready) begin
            out_d.valid = 1'b0;
        end

        case (state_q)
            FETCH: begin
                if (!pc_ok) begin
                    // Misaligned PC: report the fault instead of fetching.
                    if (slot_free) begin
                        out_d   = fault_entry;
                        state_d = FAULT;
                    end
                end else if (resp_take) begin
                    advance = 1'b1;
                    if (slot_free) begin
                        out_d = resp_entry;
                    end else begin
                        pend_d  = resp_entry;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_d        = pend_q;
                    pend_d.valid = 1'b0;
                    state_d      = FETCH;
                end
            end
            DISCARD: begin
                if (resp_take) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
        endcase

        // Redirect overrides everything, including a same-cycle out_ready.
        if (redirect_valid) begin
            out_d.valid  = 1'b0;
            pend_d.valid = 1'b0;
            if (req_active && !iresp_data_ok) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= PC_RESET;
            req_addr_q <= PC_RESET;
            out_q      <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            out_q      <= out_d;
            pend_q     <= pend_d;
        end
    end

    assign out_valid    = out_q.valid;
    assign out_pc       = out_q.pc;
    assign out_instr    = out_q.raw_instr;
    assign out_misalign = out_q.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a bus responder with configurable
// latency, a scoreboard of expected IF/ID entries rebuilt on every
// reset/redirect from the program-order rule (target, target+4, ...), and a
// separate monitor that pops and compares on every accepted entry.
module tb_fetch_stage;

    localparam int unsigned     XLEN     = 64;
    localparam logic [63:0]     PC_RESET = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    fetch_stage #(
        .XLEN    (XLEN),
        .PC_RESET(PC_RESET)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_misalign  (out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   accepted = 0;

    // Bus responder state.
    bit          bus_busy = 1'b0;
    logic [63:0] bus_addr = '0;
    int          bus_cnt  = 0;
    int          lat_min  = 2;
    int          lat_max  = 2;
    logic [63:0] last_new_req = '0;
    int          new_req_count = 0;
    bit          data_ok_fired = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0013;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Expected program order after a restart at t.
    task automatic model_restart(input logic [63:0] t);
        exp_t e;
        exp_q.delete();
        if (t[1:0] != 2'b00) begin
            e = '{t, 32'h0, 1'b1};
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 512; i++) begin
                e.pc       = t + 64'(4 * i);
                e.instr    = mem_word(e.pc);
                e.misalign = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then run the bus.
    task automatic tick(input bit rst, input bit rdy, input bit redir, input logic [63:0] rpc);
        @(negedge clk);
        reset          = rst;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        iresp_data_ok  = 1'b0;
        iresp_data     = $urandom;
        if (rst) model_restart(PC_RESET);
        else if (redir) model_restart(rpc);
        #1;
        data_ok_fired = 1'b0;
        if (rst) begin
            check64("reset_no_req", 64'(ireq_valid), 64'd0);
            bus_busy = 1'b0;
        end else begin
            if (bus_busy) begin
                check64("req_held", 64'(ireq_valid), 64'd1);
                check64("req_addr_stable", ireq_addr, bus_addr);
            end
            if (ireq_valid) begin
                check64("req_aligned", 64'(ireq_addr[1:0]), 64'd0);
                if (!bus_busy) begin
                    bus_busy      = 1'b1;
                    bus_addr      = ireq_addr;
                    bus_cnt       = $urandom_range(lat_max, lat_min);
                    last_new_req  = ireq_addr;
                    new_req_count++;
                end
                if (bus_cnt == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem_word(bus_addr);
                    bus_busy      = 1'b0;
                    data_ok_fired = 1'b1;
                end else begin
                    bus_cnt--;
                end
            end
        end
    endtask

    task automatic wait_new_req(input string name, input logic [63:0] exp_addr);
        int start;
        int n;
        start = new_req_count;
        n = 0;
        while (new_req_count == start && n < 50) begin
            tick(1'b0, 1'b1, 1'b0, 64'd0);
            n++;
        end
        check64({name, "_seen"}, 64'(new_req_count != start), 64'd1);
        check64(name, last_new_req, exp_addr);
    endtask

    // Monitor: compares every accepted entry and output stability under stall.
    initial begin : monitor
        exp_t        e;
        bit          prev_hold;
        logic [63:0] prev_pc;
        logic [31:0] prev_instr;
        logic        prev_mis;
        prev_hold  = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        prev_mis   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check64("stall_valid", 64'(out_valid), 64'd1);
                    check64("stall_pc", out_pc, prev_pc);
                    check64("stall_instr", 64'(out_instr), 64'(prev_instr));
                    check64("stall_misalign", 64'(out_misalign), 64'(prev_mis));
                end
                if (out_valid && out_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check64("unexpected_entry_pc", out_pc, 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        e = exp_q.pop_front();
                        accepted++;
                        $display("entry pc=0x%h instr=0x%h mis=%0d exp_pc=0x%h", out_pc, out_instr, out_misalign, e.pc);
                        check64("entry_pc", out_pc, e.pc);
                        check64("entry_instr", 64'(out_instr), 64'(e.instr));
                        check64("entry_misalign", 64'(out_misalign), 64'(e.misalign));
                    end
                end
                prev_hold  = out_valid && !out_ready && !redirect_valid;
                prev_pc    = out_pc;
                prev_instr = out_instr;
                prev_mis   = out_misalign;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int          n;
        logic [63:0] tgt;
        bit          rdy, redir, rst;
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;

        // Reset and first fetch with fixed latency 2.
        tick(1'b1, 1'b0, 1'b0, 64'd0);
        tick(1'b1, 1'b0, 1'b0, 64'd0);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_out_pc", out_pc, 64'd0);
        check64("rst_out_instr", 64'(out_instr), 64'd0);
        check64("rst_out_misalign", 64'(out_misalign), 64'd0);
        check64("rst_ireq_valid", 64'(ireq_valid), 64'd1);
        check64("rst_ireq_addr", ireq_addr, PC_RESET);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("t1_data_ok_cycle", 64'(data_ok_fired), 64'd1);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("t1_out_valid", 64'(out_valid), 64'd1);
        check64("t1_out_pc", out_pc, 64'h8000_0000);
        check64("t1_out_instr", 64'(out_instr), 64'h13);
        check64("t1_next_addr", ireq_addr, 64'h8000_0004);

        // Stall decode across two fetches: second lands in HOLD.
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0, 64'd0);
        check64("t2_hold_no_req", 64'(ireq_valid), 64'd0);
        check64("t2_hold_valid", 64'(out_valid), 64'd1);
        check64("t2_hold_pc", out_pc, 64'h8000_0004);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 64'd0);

        // Redirect while request to 0x8000_0008 is pending.
        tick(1'b1, 1'b0, 1'b0, 64'd0);
        n = 0;
        while (!(bus_busy && last_new_req == 64'h8000_0008) && n < 40) begin
            tick(1'b0, 1'b1, 1'b0, 64'd0);
            n++;
        end
        check64("t3_req_found", 64'(bus_busy && last_new_req == 64'h8000_0008), 64'd1);
        tick(1'b0, 1'b1, 1'b1, 64'h8000_0100);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("t3_discard_valid", 64'(ireq_valid), 64'd1);
        check64("t3_discard_addr", ireq_addr, 64'h8000_0008);
        wait_new_req("t3_next_req", 64'h8000_0100);

        // Redirect in the same cycle as data_ok.
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        tick(1'b0, 1'b1, 1'b1, 64'h8000_0200);
        check64("t4_data_ok_same", 64'(data_ok_fired), 64'd1);
        n = new_req_count;
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("t4_immediate_req", 64'(new_req_count - n), 64'd1);
        check64("t4_req_addr", last_new_req, 64'h8000_0200);
        check64("t4_no_old_out", 64'(out_valid), 64'd0);

        // Misaligned redirect -> fault entry, no fetches until redirected.
        tick(1'b0, 1'b0, 1'b1, 64'h8000_0002);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 64'd0);
        check64("t5_no_req", 64'(ireq_valid), 64'd0);
        check64("t5_valid", 64'(out_valid), 64'd1);
        check64("t5_misalign", 64'(out_misalign), 64'd1);
        check64("t5_instr", 64'(out_instr), 64'd0);
        check64("t5_pc", out_pc, 64'h8000_0002);
        tick(1'b0, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("t5_fault_idle_req", 64'(ireq_valid), 64'd0);
        check64("t5_fault_idle_out", 64'(out_valid), 64'd0);
        tick(1'b0, 1'b1, 1'b1, 64'h8000_0000);
        wait_new_req("t5_restart_req", 64'h8000_0000);

        // Reset while discarding.
        tick(1'b0, 1'b1, 1'b1, 64'h8000_0300);
        tick(1'b1, 1'b1, 1'b0, 64'd0);
        tick(1'b0, 1'b0, 1'b0, 64'd0);
        check64("t6_out_valid", 64'(out_valid), 64'd0);
        check64("t6_out_pc", out_pc, 64'd0);
        check64("t6_out_instr", 64'(out_instr), 64'd0);
        check64("t6_req_valid", 64'(ireq_valid), 64'd1);
        check64("t6_req_addr", ireq_addr, PC_RESET);

        // PC wrap at the top of the address space.
        tick(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 64'd0);

        // Randomized traffic.
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(9, 0) < 7);
            redir = ($urandom_range(99, 0) < 3);
            rst   = ($urandom_range(999, 0) < 3);
            n     = $urandom_range(99, 0);
            if (n < 10)      tgt = PC_RESET + 64'($urandom_range(4095, 0)) * 4 + 64'($urandom_range(3, 1));
            else if (n < 15) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3, 0)) * 4;
            else             tgt = PC_RESET + 64'($urandom_range(4095, 0)) * 4;
            tick(rst, rdy, redir, tgt);
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 64'd0);
        check64("progress", 64'(accepted > 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
